// File: rtl/ldm_stm_seq_if.sv
// Decode-side bus of the LDM/STM sequencer: the held decode instruction going in,
// stall/bubble controls and the single-register micro-op coming out.
interface ldm_stm_seq_if #(
  parameter int REGW = 4,
  parameter int XLEN = 32
);
  logic            armD;
  logic            validD;
  logic [31:0]     instrD;
  logic            stallD;
  logic            flushD;
  logic            seq_stall;
  logic            seq_bubble;
  logic            uop_valid;
  logic            uop_load;
  logic [REGW-1:0] uop_base;
  logic [REGW-1:0] uop_rd;
  logic [XLEN-1:0] uop_offset;
  logic            uop_last;
  logic            uop_wb;
  logic [XLEN-1:0] uop_wboff;

  modport master (
    output armD, validD, instrD, stallD, flushD,
    input  seq_stall, seq_bubble, uop_valid, uop_load, uop_base, uop_rd,
    input  uop_offset, uop_last, uop_wb, uop_wboff
  );

  modport slave (
    input  armD, validD, instrD, stallD, flushD,
    output seq_stall, seq_bubble, uop_valid, uop_load, uop_base, uop_rd,
    output uop_offset, uop_last, uop_wb, uop_wboff
  );
endinterface

// File: rtl/ldm_stm_seq.sv
// Decode-stage LDM/STM sequencer: holds the block transfer in D and issues one
// single-register load/store micro-op per cycle, lowest register first.
module ldm_stm_seq #(
  parameter int REGW = 4,
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  ldm_stm_seq_if.slave bus
);

  localparam int NREG = 1 << REGW;
  localparam logic [XLEN-1:0] OFF_STEP = XLEN'(32'd4);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic logic [REGW:0] popcount(input logic [NREG-1:0] m);
    logic [REGW:0] cnt;
    cnt = {(REGW+1){1'b0}};
    for (int i = 0; i < NREG; i++) begin
      cnt = cnt + {{REGW{1'b0}}, m[i]};
    end
    return cnt;
  endfunction

  function automatic logic [REGW-1:0] lowest_idx(input logic [NREG-1:0] m);
    logic [REGW-1:0] idx;
    idx = {REGW{1'b0}};
    for (int i = NREG - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = i[REGW-1:0];
      end
    end
    return idx;
  endfunction

  function automatic logic [NREG-1:0] clear_lowest(input logic [NREG-1:0] m);
    return m & (m - {{(NREG-1){1'b0}}, 1'b1});
  endfunction

  function automatic logic single_bit(input logic [NREG-1:0] m);
    return (m != {NREG{1'b0}}) && (clear_lowest(m) == {NREG{1'b0}});
  endfunction

  state_e          state_q, state_d;
  logic [NREG-1:0] mask_q, mask_d;
  logic            w_q, w_d;
  logic            uop_valid_q, uop_valid_d;
  logic            uop_load_q, uop_load_d;
  logic [REGW-1:0] uop_base_q, uop_base_d;
  logic [REGW-1:0] uop_rd_q, uop_rd_d;
  logic [XLEN-1:0] uop_offset_q, uop_offset_d;
  logic            uop_last_q, uop_last_d;
  logic            uop_wb_q, uop_wb_d;
  logic [XLEN-1:0] uop_wboff_q, uop_wboff_d;

  logic            seq_stall_s;
  logic            seq_bubble_s;
  logic [NREG-1:0] list_s;
  logic [REGW:0]   n_s;
  logic [XLEN-1:0] four_n_s;
  logic [XLEN-1:0] neg_four_n_s;
  logic [XLEN-1:0] start_s;
  logic [XLEN-1:0] wboff_s;
  logic            hit_s;
  logic            accept_s;
  logic            unused_s;

  assign list_s       = bus.instrD[NREG-1:0];
  assign n_s          = popcount(list_s);
  assign four_n_s     = {{(XLEN-REGW-1){1'b0}}, n_s} << 2'd2;
  assign neg_four_n_s = {XLEN{1'b0}} - four_n_s;
  assign hit_s        = bus.validD & bus.armD & (bus.instrD[27:25] == 3'b100)
                      & (state_q == S_IDLE) & ~bus.flushD;
  assign accept_s     = hit_s & (n_s != {(REGW+1){1'b0}}) & ~bus.stallD;
  // Condition field and S bit are resolved downstream per micro-op.
  assign unused_s     = ^{bus.instrD[31:28], bus.instrD[22]};

  // Start offset from the P/U addressing mode and the base writeback delta.
  always_comb begin
    start_s = {XLEN{1'b0}};
    case ({bus.instrD[24], bus.instrD[23]})
      2'b01:   start_s = {XLEN{1'b0}};
      2'b11:   start_s = OFF_STEP;
      2'b00:   start_s = OFF_STEP - four_n_s;
      2'b10:   start_s = neg_four_n_s;
      default: start_s = {XLEN{1'b0}};
    endcase
    if (bus.instrD[23]) begin
      wboff_s = four_n_s;
    end else begin
      wboff_s = neg_four_n_s;
    end
  end

  // Next-state, micro-op generation and decode stall/bubble control.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    w_d          = w_q;
    uop_valid_d  = uop_valid_q;
    uop_load_d   = uop_load_q;
    uop_base_d   = uop_base_q;
    uop_rd_d     = uop_rd_q;
    uop_offset_d = uop_offset_q;
    uop_last_d   = uop_last_q;
    uop_wb_d     = uop_wb_q;
    uop_wboff_d  = uop_wboff_q;
    seq_stall_s  = 1'b0;
    seq_bubble_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d      = S_RUN;
          seq_stall_s  = 1'b1;
          seq_bubble_s = 1'b1;
          w_d          = bus.instrD[21];
          mask_d       = clear_lowest(list_s);
          uop_valid_d  = 1'b1;
          uop_load_d   = bus.instrD[20];
          uop_base_d   = bus.instrD[19:16];
          uop_rd_d     = lowest_idx(list_s);
          uop_offset_d = start_s;
          uop_last_d   = single_bit(list_s);
          uop_wb_d     = bus.instrD[21] & single_bit(list_s);
          uop_wboff_d  = wboff_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        seq_bubble_s = 1'b1;
        // Release D in the cycle the final micro-op is presented, unless held.
        seq_stall_s  = ~uop_last_q | bus.stallD;
        if (bus.stallD) begin
          state_d = S_RUN;
        end else if (uop_last_q) begin
          state_d     = S_IDLE;
          mask_d      = {NREG{1'b0}};
          uop_valid_d = 1'b0;
          uop_last_d  = 1'b0;
          uop_wb_d    = 1'b0;
        end else begin
          uop_rd_d     = lowest_idx(mask_q);
          uop_offset_d = uop_offset_q + OFF_STEP;
          uop_last_d   = single_bit(mask_q);
          uop_wb_d     = w_q & single_bit(mask_q);
          mask_d       = clear_lowest(mask_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.flushD) begin
      state_d     = S_IDLE;
      mask_d      = {NREG{1'b0}};
      uop_valid_d = 1'b0;
      uop_last_d  = 1'b0;
      uop_wb_d    = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State and micro-op registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mask_q       <= {NREG{1'b0}};
      w_q          <= 1'b0;
      uop_valid_q  <= 1'b0;
      uop_load_q   <= 1'b0;
      uop_base_q   <= {REGW{1'b0}};
      uop_rd_q     <= {REGW{1'b0}};
      uop_offset_q <= {XLEN{1'b0}};
      uop_last_q   <= 1'b0;
      uop_wb_q     <= 1'b0;
      uop_wboff_q  <= {XLEN{1'b0}};
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      w_q          <= w_d;
      uop_valid_q  <= uop_valid_d;
      uop_load_q   <= uop_load_d;
      uop_base_q   <= uop_base_d;
      uop_rd_q     <= uop_rd_d;
      uop_offset_q <= uop_offset_d;
      uop_last_q   <= uop_last_d;
      uop_wb_q     <= uop_wb_d;
      uop_wboff_q  <= uop_wboff_d;
    end
  end

  assign bus.seq_stall  = seq_stall_s;
  assign bus.seq_bubble = seq_bubble_s;
  assign bus.uop_valid  = uop_valid_q;
  assign bus.uop_load   = uop_load_q;
  assign bus.uop_base   = uop_base_q;
  assign bus.uop_rd     = uop_rd_q;
  assign bus.uop_offset = uop_offset_q;
  assign bus.uop_last   = uop_last_q;
  assign bus.uop_wb     = uop_wb_q;
  assign bus.uop_wboff  = uop_wboff_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: directed block transfers plus randomized
// LDM/STM streams compared against an address-level model of ARM block transfers.
module tb_ldm_stm_seq;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  ldm_stm_seq_if #(.REGW(4), .XLEN(32)) bus ();

  ldm_stm_seq #(.REGW(4), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one instruction through D and checks every cycle until the sequence
  // releases D. abort_kind: 0 none, 1 flushD, 2 reset, applied when micro-op
  // number abort_j (1-based) is on the outputs.
  task automatic run_seq(input logic [31:0] instr, input logic arm, input int pre_stall,
                         input int stall_j, input int stall_len,
                         input int abort_j, input int abort_kind);
    int          regs[$];
    int          n;
    int          j;
    int          stalls_left;
    int          issued;
    int          lo_addr;
    logic [31:0] exp_off;
    logic [31:0] exp_wboff;
    logic [3:0]  exp_rd;
    logic        is_seq;
    logic        exp_stall;
    for (int i = 0; i < 16; i++) begin
      if (instr[i]) regs.push_back(i);
    end
    n = regs.size();
    // Lowest address touched relative to Rn, by addressing mode.
    if (instr[23]) lo_addr = instr[24] ? 4 : 0;
    else           lo_addr = instr[24] ? -4 * n : 4 - 4 * n;
    exp_wboff = instr[23] ? 32'(4 * n) : 32'(-4 * n);
    is_seq = arm && (instr[27:25] == 3'b100) && (n > 0);

    for (int c = 0; c < pre_stall; c++) begin
      @(negedge clk);
      bus.validD = 1'b1; bus.armD = arm; bus.instrD = instr;
      bus.stallD = 1'b1; bus.flushD = 1'b0;
      #1;
      total++;
      if (bus.uop_valid !== 1'b0) begin
        bad++; $display("FAIL stalled_accept: uop_valid got %b expected 0", bus.uop_valid);
      end
    end

    @(negedge clk);
    bus.validD = 1'b1; bus.armD = arm; bus.instrD = instr;
    bus.stallD = 1'b0; bus.flushD = 1'b0;
    #1;
    total++;
    if (bus.uop_valid !== 1'b0) begin
      bad++; $display("FAIL accept_valid: uop_valid got %b expected 0", bus.uop_valid);
    end
    total++;
    if ({bus.seq_stall, bus.seq_bubble} !== {is_seq, is_seq}) begin
      bad++; $display("FAIL accept_ctrl: stall/bubble got %b%b expected %b%b",
                      bus.seq_stall, bus.seq_bubble, is_seq, is_seq);
    end
    if (!is_seq) return;

    j = 1;
    stalls_left = stall_len;
    issued = 0;
    while (j <= n) begin
      @(negedge clk);
      bus.stallD = (j == stall_j) && (stalls_left > 0);
      bus.flushD = (abort_kind == 1) && (abort_j == j);
      reset      = (abort_kind == 2) && (abort_j == j);
      #1;
      exp_rd    = 4'(regs[j-1]);
      exp_off   = 32'(lo_addr + 4 * (j - 1));
      exp_stall = (j < n) || bus.stallD;
      total++;
      if (bus.uop_valid !== 1'b1) begin
        bad++; $display("FAIL uop_valid k=%0d: got %b expected 1", j, bus.uop_valid);
      end
      total++;
      if (bus.uop_rd !== exp_rd) begin
        bad++; $display("FAIL uop_rd k=%0d: got %0d expected %0d", j, bus.uop_rd, exp_rd);
      end
      total++;
      if (bus.uop_offset !== exp_off) begin
        bad++; $display("FAIL uop_offset k=%0d: got %h expected %h", j, bus.uop_offset, exp_off);
      end
      total++;
      if ({bus.uop_load, bus.uop_base} !== {instr[20], instr[19:16]}) begin
        bad++; $display("FAIL load_base k=%0d: got %b/%0d expected %b/%0d", j,
                        bus.uop_load, bus.uop_base, instr[20], instr[19:16]);
      end
      total++;
      if ({bus.uop_last, bus.uop_wb} !== {(j == n), instr[21] && (j == n)}) begin
        bad++; $display("FAIL last_wb k=%0d: got %b%b expected %b%b", j, bus.uop_last,
                        bus.uop_wb, (j == n), instr[21] && (j == n));
      end
      total++;
      if (bus.uop_wboff !== exp_wboff) begin
        bad++; $display("FAIL uop_wboff k=%0d: got %h expected %h", j, bus.uop_wboff, exp_wboff);
      end
      total++;
      if ({bus.seq_stall, bus.seq_bubble} !== {exp_stall, 1'b1}) begin
        bad++; $display("FAIL run_ctrl k=%0d: stall/bubble got %b%b expected %b1", j,
                        bus.seq_stall, bus.seq_bubble, exp_stall);
      end
      if (bus.uop_valid === 1'b1 && !bus.stallD) issued++;
      if (abort_kind != 0 && abort_j == j) begin
        @(negedge clk);
        bus.flushD = 1'b0; reset = 1'b0; bus.validD = 1'b0; bus.stallD = 1'b0;
        #1;
        total++;
        if ({bus.uop_valid, bus.seq_stall, bus.seq_bubble} !== 3'b000) begin
          bad++; $display("FAIL abort: valid/stall/bubble got %b%b%b expected 000",
                          bus.uop_valid, bus.seq_stall, bus.seq_bubble);
        end
        if (abort_kind == 2) begin
          total++;
          if ({bus.uop_rd, bus.uop_offset, bus.uop_last, bus.uop_wboff} !== 70'd0) begin
            bad++; $display("FAIL reset_outputs: rd=%0d off=%h last=%b wboff=%h expected zeros",
                            bus.uop_rd, bus.uop_offset, bus.uop_last, bus.uop_wboff);
          end
        end
        return;
      end
      if (bus.stallD) stalls_left--;
      else j++;
    end
    total++;
    if (issued != n) begin
      bad++; $display("FAIL uop_count: got %0d expected %0d", issued, n);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.validD = 1'b0; bus.stallD = 1'b0; bus.flushD = 1'b0;
    #1;
    total++;
    if ({bus.uop_valid, bus.seq_stall, bus.seq_bubble} !== 3'b000) begin
      bad++; $display("FAIL idle: valid/stall/bubble got %b%b%b expected 000",
                      bus.uop_valid, bus.seq_stall, bus.seq_bubble);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.validD = 1'b0; bus.armD = 1'b0; bus.instrD = 32'd0;
    bus.stallD = 1'b0; bus.flushD = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({bus.uop_valid, bus.uop_load, bus.uop_base, bus.uop_rd, bus.uop_offset,
         bus.uop_last, bus.uop_wb, bus.uop_wboff, bus.seq_stall, bus.seq_bubble} !== 79'd0) begin
      bad++; $display("FAIL reset_state: valid=%b rd=%0d off=%h wboff=%h expected zeros",
                      bus.uop_valid, bus.uop_rd, bus.uop_offset, bus.uop_wboff);
    end
  endtask

  task automatic test_ldmia();
    run_seq(32'hE8900026, 1'b1, 0, 0, 0, 0, 0);
    idle_cycle();
  endtask

  task automatic test_stmdb();
    run_seq(32'hE92D4010, 1'b1, 0, 0, 0, 0, 0);
    idle_cycle();
  endtask

  task automatic test_full_list();
    run_seq(32'hE993FFFF, 1'b1, 0, 0, 0, 0, 0);
    idle_cycle();
    run_seq(32'hE813FFFF, 1'b1, 0, 0, 0, 0, 0);
    idle_cycle();
  endtask

  task automatic test_empty();
    run_seq(32'hE8900000, 1'b1, 0, 0, 0, 0, 0);
    idle_cycle();
    run_seq(32'hE8900026, 1'b0, 0, 0, 0, 0, 0);
    idle_cycle();
  endtask

  task automatic test_stall();
    run_seq(32'hE8900026, 1'b1, 2, 1, 2, 0, 0);
    idle_cycle();
  endtask

  task automatic test_flush();
    run_seq(32'hE8900026, 1'b1, 0, 0, 0, 2, 1);
    run_seq(32'hE8900026, 1'b1, 0, 0, 0, 0, 0);
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    run_seq(32'hE8900026, 1'b1, 0, 0, 0, 2, 2);
    run_seq(32'hE92D4010, 1'b1, 0, 0, 0, 0, 0);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    run_seq(32'hE8900026, 1'b1, 0, 0, 0, 0, 0);
    run_seq(32'hE92D4010, 1'b1, 0, 0, 0, 0, 0);
    run_seq(32'hE8B18001, 1'b1, 0, 0, 0, 0, 0);
    idle_cycle();
  endtask

  task automatic test_random();
    logic [31:0] instr;
    logic [15:0] lst;
    logic        arm;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 7))
        0:       lst = 16'h0000;
        1:       lst = 16'h0001 << $urandom_range(0, 15);
        2:       lst = 16'hFFFF;
        default: lst = 16'($urandom);
      endcase
      instr = {4'hE, 3'b100, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom),
               1'($urandom), 4'($urandom), lst};
      if ($urandom_range(0, 9) == 0) instr[27:25] = 3'b101;
      arm = ($urandom_range(0, 4) != 0);
      run_seq(instr, arm, $urandom_range(0, 2), $urandom_range(1, 16),
              $urandom_range(0, 2), 0, 0);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.validD = 1'b0; bus.armD = 1'b0; bus.instrD = 32'd0;
    bus.stallD = 1'b0; bus.flushD = 1'b0;
    test_reset();
    test_ldmia();
    test_stmdb();
    test_full_list();
    test_empty();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
